// File: rtl/axis_udp_filter_mp_if.sv
// AXI-Stream bundle used on both sides of axis_udp_filter_mp: tvalid/tready handshake, data, byte strobes, last.
interface axis_udp_filter_mp_if #(
  parameter int DW = 64
);
  logic            tvalid;
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tstrb;
  logic            tlast;
  logic            tready;

  modport master (output tvalid, output tdata, output tstrb, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tstrb, input tlast, output tready);
endinterface

// File: rtl/axis_udp_filter_mp.sv
// Buffers the Eth/IPv4/UDP header beats, matches the UDP dst port against a list (allow/block), then forwards or drops the frame.
// Define AXIS_UDP_FILTER_STATS_EN to add pass_cnt_o/drop_cnt_o; first beat out 2 cycles after the last header beat.
module axis_udp_filter_mp #(
  parameter int AXIS_DATA_WIDTH = 64,
  parameter int NUM_PORTS       = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  axis_udp_filter_mp_if.slave     s_axis,
  axis_udp_filter_mp_if.master    m_axis,
  input  logic                    en_i,
  input  logic                    mode_i,
  input  logic [NUM_PORTS*16-1:0] port_list_i,
  input  logic [NUM_PORTS-1:0]    port_valid_i
`ifdef AXIS_UDP_FILTER_STATS_EN
  ,
  output logic [31:0]             pass_cnt_o,
  output logic [31:0]             drop_cnt_o
`endif
);
  localparam int DW        = AXIS_DATA_WIDTH;
  localparam int SW        = DW / 8;
  localparam int HDR_BEATS = (320 + DW - 1) / DW;
  localparam int CW        = $clog2(HDR_BEATS + 1);
  localparam int PORT_BEAT = 37 / SW;

  typedef enum logic [2:0] {IDLE, HDR, DECIDE, FLUSH, PASS, DROP} state_t;

  state_t                  r_state;
  logic [DW-1:0]           r_buf_dat  [HDR_BEATS];
  logic [SW-1:0]           r_buf_strb [HDR_BEATS];
  logic                    r_buf_last [HDR_BEATS];
  logic [CW-1:0]           r_cnt;
  logic [CW-1:0]           r_rd;
  logic                    r_hdr_last;
  logic                    r_mode;
  logic [NUM_PORTS*16-1:0] r_plist;
  logic [NUM_PORTS-1:0]    r_pvld;
  logic                    r_out_vld;
  logic [DW-1:0]           r_out_dat;
  logic [SW-1:0]           r_out_strb;
  logic                    r_out_last;

  logic          w_s_rdy;
  logic          w_s_acc;
  logic          w_out_free;
  logic          w_hdr_full;
  logic          w_is_udp;
  logic          w_port_hit;
  logic          w_pass;
  logic          w_flush_last;
  logic [15:0]   w_ethertype;
  logic [7:0]    w_ver_ihl;
  logic [7:0]    w_proto;
  logic [15:0]   w_port;
  logic [DW-1:0] w_rd_dat;
  logic [SW-1:0] w_rd_strb;
  logic          w_rd_last;

  // Frame byte b lives in beat b/SW, lane b%SW; stale beats past r_cnt are masked by w_hdr_full.
  assign w_ethertype = {r_buf_dat[12/SW][8*(12%SW) +: 8], r_buf_dat[13/SW][8*(13%SW) +: 8]};
  assign w_ver_ihl   = r_buf_dat[14/SW][8*(14%SW) +: 8];
  assign w_proto     = r_buf_dat[23/SW][8*(23%SW) +: 8];
  assign w_port      = {r_buf_dat[36/SW][8*(36%SW) +: 8], r_buf_dat[37/SW][8*(37%SW) +: 8]};
  assign w_hdr_full  = (r_cnt > CW'(PORT_BEAT));
  assign w_is_udp    = w_hdr_full && (w_ethertype == 16'h0800) && (w_ver_ihl == 8'h45) && (w_proto == 8'h11);

  always_comb begin
    w_port_hit = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (r_pvld[k] && (r_plist[16*k +: 16] == w_port)) w_port_hit = 1'b1;
    end
  end

  assign w_pass = (w_is_udp && w_port_hit) ^ r_mode;

  always_comb begin
    w_rd_dat  = '0;
    w_rd_strb = '0;
    w_rd_last = 1'b0;
    for (int i = 0; i < HDR_BEATS; i++) begin
      if (r_rd == CW'(i)) begin
        w_rd_dat  = r_buf_dat[i];
        w_rd_strb = r_buf_strb[i];
        w_rd_last = r_buf_last[i];
      end
    end
  end

  always_comb begin
    w_s_rdy = 1'b0;
    case (r_state)
      IDLE:      w_s_rdy = en_i;
      HDR, DROP: w_s_rdy = 1'b1;
      PASS:      w_s_rdy = !r_out_vld || m_axis.tready;
      default:   w_s_rdy = 1'b0;
    endcase
    if (rst_i) w_s_rdy = 1'b0;
  end

  assign s_axis.tready = w_s_rdy;
  assign w_s_acc       = s_axis.tvalid && w_s_rdy;
  assign w_out_free    = !r_out_vld || m_axis.tready;
  assign w_flush_last  = (r_rd == r_cnt - 1'b1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_rd       <= '0;
      r_hdr_last <= 1'b0;
      r_mode     <= 1'b0;
      r_plist    <= '0;
      r_pvld     <= '0;
      r_out_vld  <= 1'b0;
      r_out_dat  <= '0;
      r_out_strb <= '0;
      r_out_last <= 1'b0;
      for (int i = 0; i < HDR_BEATS; i++) begin
        r_buf_dat[i]  <= '0;
        r_buf_strb[i] <= '0;
        r_buf_last[i] <= 1'b0;
      end
    end else begin
      if (m_axis.tready) r_out_vld <= 1'b0;
      case (r_state)
        IDLE: if (w_s_acc) begin
          r_buf_dat[0]  <= s_axis.tdata;
          r_buf_strb[0] <= s_axis.tstrb;
          r_buf_last[0] <= s_axis.tlast;
          r_cnt         <= CW'(1);
          r_hdr_last    <= s_axis.tlast;
          r_mode        <= mode_i;
          r_plist       <= port_list_i;
          r_pvld        <= port_valid_i;
          r_state       <= s_axis.tlast ? DECIDE : HDR;
        end
        HDR: if (w_s_acc) begin
          for (int i = 0; i < HDR_BEATS; i++) begin
            if (r_cnt == CW'(i)) begin
              r_buf_dat[i]  <= s_axis.tdata;
              r_buf_strb[i] <= s_axis.tstrb;
              r_buf_last[i] <= s_axis.tlast;
            end
          end
          r_cnt      <= r_cnt + 1'b1;
          r_hdr_last <= s_axis.tlast;
          if (s_axis.tlast || (r_cnt == CW'(HDR_BEATS - 1))) r_state <= DECIDE;
        end
        DECIDE: begin
          r_rd <= '0;
          if (w_pass)          r_state <= FLUSH;
          else if (r_hdr_last) r_state <= IDLE;
          else                 r_state <= DROP;
        end
        FLUSH: if (w_out_free) begin
          r_out_vld  <= 1'b1;
          r_out_dat  <= w_rd_dat;
          r_out_strb <= w_rd_strb;
          r_out_last <= w_rd_last;
          r_rd       <= r_rd + 1'b1;
          if (w_flush_last) r_state <= w_rd_last ? IDLE : PASS;
        end
        PASS: if (w_s_acc) begin
          r_out_vld  <= 1'b1;
          r_out_dat  <= s_axis.tdata;
          r_out_strb <= s_axis.tstrb;
          r_out_last <= s_axis.tlast;
          if (s_axis.tlast) r_state <= IDLE;
        end
        DROP: if (w_s_acc && s_axis.tlast) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m_axis.tvalid = r_out_vld;
  assign m_axis.tdata  = r_out_dat;
  assign m_axis.tstrb  = r_out_strb;
  assign m_axis.tlast  = r_out_last;

`ifdef AXIS_UDP_FILTER_STATS_EN
  logic [31:0] r_pass_cnt;
  logic [31:0] r_drop_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pass_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (r_out_vld && m_axis.tready && r_out_last) r_pass_cnt <= r_pass_cnt + 32'd1;
      if ((r_state == DECIDE) && !w_pass)           r_drop_cnt <= r_drop_cnt + 32'd1;
    end
  end

  assign pass_cnt_o = r_pass_cnt;
  assign drop_cnt_o = r_drop_cnt;
`endif
endmodule

// File: tb/tb_axis_udp_filter_mp.sv
// Directed bench for axis_udp_filter_mp: a 64-bit and a 128-bit instance driven by per-scenario tasks.
module tb_axis_udp_filter_mp;
  logic clk = 1'b0;
  logic rst;
  int   cyc  = 0;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axis_udp_filter_mp_if #(.DW(64))  s64 ();
  axis_udp_filter_mp_if #(.DW(64))  m64 ();
  axis_udp_filter_mp_if #(.DW(128)) s128 ();
  axis_udp_filter_mp_if #(.DW(128)) m128 ();

  logic        en64, mode64, en128, mode128;
  logic [63:0] plist64, plist128;
  logic [3:0]  pvld64, pvld128;

  logic       bp_en  = 1'b0;
  logic [3:0] bp_pat = 4'b1001;
  logic [1:0] bp_ph  = 2'd0;
  always @(posedge clk) bp_ph <= bp_ph + 2'd1;
  assign m64.tready  = bp_en ? bp_pat[bp_ph] : 1'b1;
  assign m128.tready = 1'b1;

`ifdef AXIS_UDP_FILTER_STATS_EN
  logic [31:0] pc64, dc64, pc128, dc128;
`endif

  axis_udp_filter_mp #(.AXIS_DATA_WIDTH(64), .NUM_PORTS(4)) u_dut64 (
    .clk_i(clk), .rst_i(rst), .s_axis(s64), .m_axis(m64), .en_i(en64), .mode_i(mode64),
    .port_list_i(plist64), .port_valid_i(pvld64)
`ifdef AXIS_UDP_FILTER_STATS_EN
    , .pass_cnt_o(pc64), .drop_cnt_o(dc64)
`endif
  );

  axis_udp_filter_mp #(.AXIS_DATA_WIDTH(128), .NUM_PORTS(4)) u_dut128 (
    .clk_i(clk), .rst_i(rst), .s_axis(s128), .m_axis(m128), .en_i(en128), .mode_i(mode128),
    .port_list_i(plist128), .port_valid_i(pvld128)
`ifdef AXIS_UDP_FILTER_STATS_EN
    , .pass_cnt_o(pc128), .drop_cnt_o(dc128)
`endif
  );

  // Output capture and hold-stability watch, sampled on the falling edge.
  logic [63:0]  q64d[$];
  logic [7:0]   q64s[$];
  logic         q64l[$];
  logic [127:0] q128d[$];
  logic [15:0]  q128s[$];
  logic         q128l[$];
  bit           seen64, seen128, hold64;
  int           first64, viol64, stall64;
  logic [63:0]  hd64;
  logic [7:0]   hs64;
  logic         hl64;

  always @(negedge clk) begin
    if (hold64 && (m64.tvalid !== 1'b1 || m64.tdata !== hd64 || m64.tstrb !== hs64 || m64.tlast !== hl64))
      viol64++;
    hold64 = m64.tvalid && !m64.tready;
    hd64 = m64.tdata; hs64 = m64.tstrb; hl64 = m64.tlast;
    if (m64.tvalid && !m64.tready) stall64++;
    if (m64.tvalid && !seen64) begin seen64 = 1'b1; first64 = cyc; end
    if (m64.tvalid && m64.tready) begin
      q64d.push_back(m64.tdata); q64s.push_back(m64.tstrb); q64l.push_back(m64.tlast);
    end
    if (m128.tvalid) seen128 = 1'b1;
    if (m128.tvalid && m128.tready) begin
      q128d.push_back(m128.tdata); q128s.push_back(m128.tstrb); q128l.push_back(m128.tlast);
    end
  end

  logic [7:0] fr [0:255];
  int         fr_len;

  task automatic build_frame(input int len, input logic [15:0] etype, input logic [15:0] port, input logic [7:0] seed);
    fr_len = len;
    for (int i = 0; i < 256; i++) fr[i] = 8'(i * 7) ^ seed;
    fr[12] = etype[15:8]; fr[13] = etype[7:0];
    fr[14] = 8'h45; fr[23] = 8'h11;
    fr[36] = port[15:8]; fr[37] = port[7:0];
  endtask

  function automatic logic [127:0] exp_dat(input int b, input int nb);
    logic [127:0] d;
    d = '0;
    for (int j = 0; j < nb; j++) if (b * nb + j < fr_len) d[8*j +: 8] = fr[b * nb + j];
    return d;
  endfunction

  function automatic logic [15:0] exp_strb(input int b, input int nb);
    logic [15:0] s;
    s = '0;
    for (int j = 0; j < nb; j++) if (b * nb + j < fr_len) s[j] = 1'b1;
    return s;
  endfunction

  task automatic clr();
    q64d.delete(); q64s.delete(); q64l.delete();
    q128d.delete(); q128s.delete(); q128l.delete();
    seen64 = 1'b0; seen128 = 1'b0; viol64 = 0; stall64 = 0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives fr[] as a frame on the chosen instance; a4 = cycle value right after beat 4 is accepted.
  task automatic send(input int w, input int max_beats, input int chg_beat, input logic [3:0] chg_pvld,
                      output int cycles, output int a4);
    int nb, total, nbeats, t;
    logic [127:0] d;
    logic [15:0] st;
    logic acc, lst;
    nb = w / 8;
    total = (fr_len + nb - 1) / nb;
    nbeats = (max_beats < total) ? max_beats : total;
    cycles = 0; a4 = -1;
    for (int b = 0; b < nbeats; b++) begin
      d = exp_dat(b, nb); st = exp_strb(b, nb); lst = (b == total - 1);
      if (b == chg_beat) begin
        if (w == 64) pvld64 = chg_pvld; else pvld128 = chg_pvld;
      end
      if (w == 64) begin
        s64.tvalid = 1'b1; s64.tdata = d[63:0]; s64.tstrb = st[7:0]; s64.tlast = lst;
      end else begin
        s128.tvalid = 1'b1; s128.tdata = d; s128.tstrb = st; s128.tlast = lst;
      end
      acc = 1'b0; t = 0;
      while (!acc && t < 100) begin
        @(negedge clk);
        acc = (w == 64) ? s64.tready : s128.tready;
        if (acc && b == 4) a4 = cyc + 1;
        @(posedge clk); #1;
        t++; cycles++;
      end
      if (!acc) begin
        nvec++; nerr++;
        $display("FAIL send_timeout w%0d beat%0d: tready low for 100 cycles, expected an accept", w, b);
      end
    end
    s64.tvalid = 1'b0; s128.tvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_cyc(2);
    @(negedge clk);
    nvec++; if (m64.tvalid !== 1'b0 || m64.tlast !== 1'b0) begin nerr++; $display("FAIL rst_m64_vld_last: got %b/%b, want 0/0", m64.tvalid, m64.tlast); end
    nvec++; if (m64.tdata !== 64'h0 || m64.tstrb !== 8'h0) begin nerr++; $display("FAIL rst_m64_dat: got %h/%h, want 0/0", m64.tdata, m64.tstrb); end
    nvec++; if (s64.tready !== 1'b0) begin nerr++; $display("FAIL rst_s64_rdy: got %b, want 0", s64.tready); end
    nvec++; if (m128.tvalid !== 1'b0 || m128.tdata !== 128'h0) begin nerr++; $display("FAIL rst_m128: got %b/%h, want 0/0", m128.tvalid, m128.tdata); end
    rst = 1'b0;
    wait_cyc(1);
    @(negedge clk);
    nvec++; if (s64.tready !== 1'b1) begin nerr++; $display("FAIL idle_rdy: got %b, want 1", s64.tready); end
`ifdef AXIS_UDP_FILTER_STATS_EN
    nvec++; if (pc64 !== 32'd0 || dc64 !== 32'd0) begin nerr++; $display("FAIL rst_cnt: got %0d/%0d, want 0/0", pc64, dc64); end
`endif
    wait_cyc(1);
  endtask

  task automatic test_enable();
    int bad;
    clr(); bad = 0;
    en64 = 1'b0;
    s64.tvalid = 1'b1; s64.tdata = 64'h1122334455667788; s64.tstrb = 8'hFF; s64.tlast = 1'b1;
    repeat (3) begin @(negedge clk); if (s64.tready !== 1'b0) bad++; end
    @(posedge clk); #1;
    s64.tvalid = 1'b0; en64 = 1'b1;
    nvec++; if (bad != 0) begin nerr++; $display("FAIL en_block: tready high %0d times, want 0", bad); end
    @(negedge clk);
    nvec++; if (s64.tready !== 1'b1) begin nerr++; $display("FAIL en_restore: got %b, want 1", s64.tready); end
    wait_cyc(2);
  endtask

  task automatic test_allow_hit();
    int cycles, a4;
    logic [127:0] d;
    logic [15:0] st;
    mode64 = 1'b0; plist64 = {16'd0, 16'd0, 16'd0, 16'd5000}; pvld64 = 4'b0001;
    build_frame(62, 16'h0800, 16'h1388, 8'h11);
    clr();
    send(64, 99, -1, 4'b0, cycles, a4);
    wait_cyc(20);
    nvec++; if (q64d.size() != 8) begin nerr++; $display("FAIL hit_count: got %0d beats, want 8", q64d.size()); end
    for (int i = 0; i < q64d.size() && i < 8; i++) begin
      d = exp_dat(i, 8); st = exp_strb(i, 8);
      nvec++;
      if (q64d[i] !== d[63:0] || q64s[i] !== st[7:0] || q64l[i] !== (i == 7)) begin
        nerr++; $display("FAIL hit_beat%0d: got %h/%h/%b, want %h/%h/%b", i, q64d[i], q64s[i], q64l[i], d[63:0], st[7:0], i == 7);
      end
    end
    nvec++; if (first64 - a4 != 2) begin nerr++; $display("FAIL hit_latency: got %0d cycles, want 2", first64 - a4); end
`ifdef AXIS_UDP_FILTER_STATS_EN
    nvec++; if (pc64 !== 32'd1) begin nerr++; $display("FAIL hit_pass_cnt: got %0d, want 1", pc64); end
`endif
  endtask

  task automatic test_allow_miss();
    int cycles, a4;
    build_frame(64, 16'h0800, 16'd53, 8'h22);
    clr();
    send(64, 99, -1, 4'b0, cycles, a4);
    wait_cyc(10);
    nvec++; if (cycles != 9) begin nerr++; $display("FAIL miss_cycles: got %0d, want 9", cycles); end
    nvec++; if (seen64 !== 1'b0 || q64d.size() != 0) begin nerr++; $display("FAIL miss_out: got vld=%b beats=%0d, want 0/0", seen64, q64d.size()); end
`ifdef AXIS_UDP_FILTER_STATS_EN
    nvec++; if (dc64 !== 32'd1) begin nerr++; $display("FAIL miss_drop_cnt: got %0d, want 1", dc64); end
`endif
  endtask

  task automatic test_blocklist();
    int cycles, a4;
    logic [127:0] d;
    logic [15:0] st;
    mode64 = 1'b1; plist64 = {16'd0, 16'd53, 16'd0, 16'd0}; pvld64 = 4'b0100;
    build_frame(64, 16'h0800, 16'd53, 8'h33);
    clr();
    send(64, 99, -1, 4'b0, cycles, a4);
    wait_cyc(10);
    nvec++; if (seen64 !== 1'b0) begin nerr++; $display("FAIL blk_drop: got tvalid seen=%b, want 0", seen64); end
    build_frame(32, 16'h0806, 16'h1388, 8'h44);
    clr();
    send(64, 99, -1, 4'b0, cycles, a4);
    wait_cyc(15);
    nvec++; if (q64d.size() != 4) begin nerr++; $display("FAIL blk_runt_count: got %0d beats, want 4", q64d.size()); end
    for (int i = 0; i < q64d.size() && i < 4; i++) begin
      d = exp_dat(i, 8); st = exp_strb(i, 8);
      nvec++;
      if (q64d[i] !== d[63:0] || q64s[i] !== st[7:0] || q64l[i] !== (i == 3)) begin
        nerr++; $display("FAIL blk_runt_beat%0d: got %h/%h/%b, want %h/%h/%b", i, q64d[i], q64s[i], q64l[i], d[63:0], st[7:0], i == 3);
      end
    end
    build_frame(45, 16'h0800, 16'd80, 8'h55);
    clr();
    send(64, 99, -1, 4'b0, cycles, a4);
    wait_cyc(15);
    nvec++; if (q64d.size() != 6) begin nerr++; $display("FAIL blk_pass_count: got %0d beats, want 6", q64d.size()); end
    for (int i = 0; i < q64d.size() && i < 6; i++) begin
      d = exp_dat(i, 8); st = exp_strb(i, 8);
      nvec++;
      if (q64d[i] !== d[63:0] || q64s[i] !== st[7:0] || q64l[i] !== (i == 5)) begin
        nerr++; $display("FAIL blk_pass_beat%0d: got %h/%h/%b, want %h/%h/%b", i, q64d[i], q64s[i], q64l[i], d[63:0], st[7:0], i == 5);
      end
    end
  endtask

  task automatic test_backpressure();
    int cycles, a4;
    logic [127:0] d;
    logic [15:0] st;
    mode64 = 1'b0; plist64 = {16'd0, 16'd0, 16'd0, 16'd5000}; pvld64 = 4'b0001;
    build_frame(80, 16'h0800, 16'h1388, 8'h66);
    clr();
    bp_en = 1'b1;
    send(64, 99, -1, 4'b0, cycles, a4);
    wait_cyc(40);
    bp_en = 1'b0;
    wait_cyc(2);
    nvec++; if (q64d.size() != 10) begin nerr++; $display("FAIL bp_count: got %0d beats, want 10", q64d.size()); end
    for (int i = 0; i < q64d.size() && i < 10; i++) begin
      d = exp_dat(i, 8); st = exp_strb(i, 8);
      nvec++;
      if (q64d[i] !== d[63:0] || q64s[i] !== st[7:0] || q64l[i] !== (i == 9)) begin
        nerr++; $display("FAIL bp_beat%0d: got %h/%h/%b, want %h/%h/%b", i, q64d[i], q64s[i], q64l[i], d[63:0], st[7:0], i == 9);
      end
    end
    nvec++; if (viol64 != 0) begin nerr++; $display("FAIL bp_stable: got %0d hold violations, want 0", viol64); end
    nvec++; if (stall64 == 0) begin nerr++; $display("FAIL bp_stalls: got 0 stalled cycles, want at least 1"); end
  endtask

  task automatic test_w128();
    int cycles, a4;
    logic [127:0] d;
    logic [15:0] st;
    mode128 = 1'b0; plist128 = {16'd0, 16'd0, 16'd5000, 16'd0}; pvld128 = 4'b0000;
    build_frame(60, 16'h0800, 16'h1388, 8'h77);
    clr();
    send(128, 99, 2, 4'b0010, cycles, a4);
    wait_cyc(10);
    nvec++; if (seen128 !== 1'b0) begin nerr++; $display("FAIL w128_invalid_drop: got tvalid seen=%b, want 0", seen128); end
    clr();
    send(128, 99, -1, 4'b0, cycles, a4);
    wait_cyc(15);
    nvec++; if (q128d.size() != 4) begin nerr++; $display("FAIL w128_count: got %0d beats, want 4", q128d.size()); end
    for (int i = 0; i < q128d.size() && i < 4; i++) begin
      d = exp_dat(i, 16); st = exp_strb(i, 16);
      nvec++;
      if (q128d[i] !== d || q128s[i] !== st || q128l[i] !== (i == 3)) begin
        nerr++; $display("FAIL w128_beat%0d: got %h/%h/%b, want %h/%h/%b", i, q128d[i], q128s[i], q128l[i], d, st, i == 3);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cycles, a4;
    logic [127:0] d;
    logic [15:0] st;
    mode64 = 1'b0; plist64 = {16'd0, 16'd0, 16'd0, 16'd5000}; pvld64 = 4'b0001;
    build_frame(64, 16'h0800, 16'h1388, 8'h88);
    clr();
    send(64, 5, -1, 4'b0, cycles, a4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    nvec++; if (m64.tvalid !== 1'b1) begin nerr++; $display("FAIL rmid_flushing: got tvalid %b, want 1", m64.tvalid); end
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    nvec++; if (m64.tvalid !== 1'b0 || m64.tdata !== 64'h0) begin nerr++; $display("FAIL rmid_cleared: got %b/%h, want 0/0", m64.tvalid, m64.tdata); end
    nvec++; if (s64.tready !== 1'b0) begin nerr++; $display("FAIL rmid_rdy: got %b, want 0", s64.tready); end
    rst = 1'b0;
    wait_cyc(2);
    build_frame(64, 16'h0800, 16'h1388, 8'h99);
    clr();
    send(64, 99, -1, 4'b0, cycles, a4);
    wait_cyc(20);
    nvec++; if (q64d.size() != 8) begin nerr++; $display("FAIL rmid_count: got %0d beats, want 8", q64d.size()); end
    for (int i = 0; i < q64d.size() && i < 8; i++) begin
      d = exp_dat(i, 8); st = exp_strb(i, 8);
      nvec++;
      if (q64d[i] !== d[63:0] || q64s[i] !== st[7:0] || q64l[i] !== (i == 7)) begin
        nerr++; $display("FAIL rmid_beat%0d: got %h/%h/%b, want %h/%h/%b", i, q64d[i], q64s[i], q64l[i], d[63:0], st[7:0], i == 7);
      end
    end
`ifdef AXIS_UDP_FILTER_STATS_EN
    nvec++; if (pc64 !== 32'd1 || dc64 !== 32'd0) begin nerr++; $display("FAIL rmid_cnt: got %0d/%0d, want 1/0", pc64, dc64); end
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000 time units, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    en64 = 1'b1; mode64 = 1'b0; plist64 = '0; pvld64 = '0;
    en128 = 1'b1; mode128 = 1'b0; plist128 = '0; pvld128 = '0;
    s64.tvalid = 1'b0; s64.tdata = '0; s64.tstrb = '0; s64.tlast = 1'b0;
    s128.tvalid = 1'b0; s128.tdata = '0; s128.tstrb = '0; s128.tlast = 1'b0;
    test_reset();
    test_enable();
    test_allow_hit();
    test_allow_miss();
    test_blocklist();
    test_backpressure();
    test_w128();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/axis_udp_filter_mp.md
# axis_udp_filter_mp

Parametrised, multi-port successor to the AXIS UDP filter front end. Sits between the MAC receive AXI-Stream and the packet FIFO; buffers the Ethernet/IPv4/UDP header beats, compares the UDP destination port against a programmable list in allowlist or blocklist mode, then either forwards the whole frame or discards it. Includes a registered output stage with full AXIS backpressure.

## Interface
- `AXIS_DATA_WIDTH`, default 64: stream width in bits; legal values are 64 and 128.
- `NUM_PORTS`, default 4: number of port-compare entries, range 1..16.
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `s_axis_tvalid/tdata/tstrb/tlast/tready`: slave stream.
  - Widths are 1/W/W/8/1/1.
  - `s_axis_tready` is the only output of this group.
- `m_axis_tvalid/tdata/tstrb/tlast/tready`: master stream.
  - Widths are 1/W/W/8/1/1.
  - `m_axis_tready` is the only input of this group.
- `en_i` in 1: filter enable; gates acceptance of new frames.
- `mode_i` in 1: 0 = allowlist (pass on match), 1 = blocklist (drop on match).
- `port_list_i` in NUM_PORTS*16: entry k occupies bits [16k+15:16k], host byte order.
- `port_valid_i` in NUM_PORTS: per-entry enable.
- `pass_cnt_o` out 32: frames forwarded. Present only with STATS_EN.
- `drop_cnt_o` out 32: frames discarded. Present only with STATS_EN.

## Operation
**Byte order**
- Byte 0 of a beat is at `tdata[7:0]`.

**Header fields (frame byte offsets)**
- Ethertype: bytes 12–13 = 0x08,0x00.
- Version/IHL: byte 14 = 0x45.
- Protocol: byte 23 = 0x11.
- UDP destination port: bytes 36–37, big-endian, so port = {b36,b37}.

**Header buffer**
- HDR_BEATS = ceil(40*8/AXIS_DATA_WIDTH), which is 5 for 64-bit and 3 for 128-bit.
- The buffer stores tdata, tstrb and tlast for each header beat.

**Match rule**
- `hit` = frame is IPv4/UDP with IHL=5 AND the port equals some entry k with `port_valid_i[k]`=1.
- Frames that are not IPv4/UDP have hit=0.
- Pass = `hit` XOR `mode_i`.

**Configuration sampling**
- `mode_i`, `port_list_i` and `port_valid_i` are sampled on the first accepted beat of a frame (SOF).
- The sampled values hold for the whole frame.

**FSM states**
- IDLE
  - `s_axis_tready` = `en_i`.
  - On an accepted beat: store it in buffer[0], go to HDR.
  - If that beat has tlast=1: go to DECIDE.
- HDR
  - tready=1; accept beats into the buffer.
  - Go to DECIDE after beat HDR_BEATS-1 is stored, or earlier if tlast=1 (runt).
- DECIDE (one cycle)
  - tready=0; evaluate pass.
  - If pass: go to FLUSH.
  - Else, if the last stored beat had tlast: go to IDLE.
  - Otherwise: go to DROP.
- FLUSH
  - tready=0; present buffered beats in order through the output register.
  - After the last buffered beat is handed off: go to IDLE if it had tlast, else PASS.
- PASS
  - Cut-through: `s_axis_tready` = !out_valid || `m_axis_tready`.
  - Return to IDLE after an accepted beat with tlast=1.
- DROP
  - tready=1; discard beats.
  - Return to IDLE on an accepted beat with tlast=1.

**Runts**
- A runt is a frame whose tlast arrives before the port bytes.
- Runts have hit=0. In blocklist mode they are forwarded intact with their original tlast.

**Enable**
- `en_i`=0 only blocks the start of a new frame; a frame already in progress completes normally.

**Pass-through**
- tstrb is forwarded unchanged.
- Data is never modified.

## Timing
**Reset values**
- `m_axis_tvalid`, `m_axis_tlast`, `s_axis_tready`: 0.
- `m_axis_tdata`, `m_axis_tstrb`: 0.
- Counters: 0.
- FSM: IDLE.

**Output register**
- `m_axis_tvalid`, `tdata`, `tstrb` and `tlast` are registered.
- Once tvalid=1, the beat holds stable until `m_axis_tready`=1.
- No combinational path from `m_axis_tready` to any `m_axis_*` signal.

**Latency**
- The first output beat is valid 2 cycles after the last header beat is accepted (DECIDE, then the first FLUSH load).
- In PASS with `m_axis_tready`=1: 1 beat per cycle, latency 1.

**Dropped frames**
- Consume 1 beat/cycle.
- Never assert `m_axis_tvalid`.

**Back-to-back frames**
- The next SOF may be accepted the cycle after the FSM enters IDLE.

**Reset mid-frame**
- Everything returns to reset values on the next edge.
- The partial frame is lost.
- Upstream is responsible for resynchronising to SOF.

**Simultaneous `s_axis` accept and `m_axis` handoff in PASS**
- Allowed; the output register reloads in the same cycle.

## Configuration
- Macro: `AXIS_UDP_FILTER_STATS_EN`.
- Defined:
  - `pass_cnt_o` increments by 1 when the tlast beat of a forwarded frame is handed off on `m_axis`.
  - `drop_cnt_o` increments by 1 at DECIDE when pass=0.
  - Both counters wrap 0xFFFFFFFF → 0.
- Undefined:
  - Both ports and both counters are absent.
  - Filtering behaviour is identical.

## Test plan
- **Allowlist hit.** W=64, mode=0, entry0=5000 valid; 8-beat UDP frame to dst port 5000 (0x1388) → 8 identical beats out, tlast on beat 7, `pass_cnt_o`=1.
- **Allowlist miss.** Same setup, dst port 53 → `s_axis_tready` high for all 8 beats, no `m_axis_tvalid`, `drop_cnt_o`=1.
- **Blocklist.** mode=1, entry2=53 valid; frame to 53 dropped; ARP frame (ethertype 0x0806) of 4 beats (a runt) forwarded intact, tlast on beat 3.
- **Backpressure.** Pass frame of 10 beats with `m_axis_tready` toggled 1,0,0,1 repeating → output data identical and in order, tvalid/tdata stable while tready=0.
- **W=128 and invalid entry.** W=128, `port_valid_i`=0 on the entry matching 5000, mode=0 → frame dropped; set valid=1 mid-frame → the current frame is still dropped, the next one passes.
- **Reset mid-frame.** `rst_i` pulsed during FLUSH → `m_axis_tvalid`=0 next cycle; the following clean frame filters correctly.
